pwm_capture: RTL

//  Receive side of the team's PWM link: samples an external PWM waveform, measures high time and period
//  in clk cycles, and reports duty_cycle on the same 10-bit scale the pwm generator consumes.

---
 rtl/pwm_capture_pkg.sv | 11 +
 rtl/pwm_capture_sync_edge.sv | 26 ++
 rtl/pwm_capture.sv | 92 +++++++++
 3 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared PWM link defaults and capture FSM state encodings.
package pwm_capture_pkg;
  localparam int DUTY_W_DEF = 10;
  localparam int CNT_W_DEF = 12;
  localparam int NOMINAL_PERIOD_DEF = 1024;
  localparam int TIMEOUT_DEF = 2048;
  localparam int SYNC_STAGES_DEF = 2;
  localparam logic [1:0] ST_WAIT_RISE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW = 2'd2;
endpackage

// File: rtl/pwm_capture_sync_edge.sv
// pwm_capture_sync_edge: synchronizer chain plus delay flop yielding level and edge pulses.
module pwm_capture_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic dly_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pwm_i};
      dly_q <= sync_q[STAGES-1];
    end
  end
  assign level_o = sync_q[STAGES-1];
  assign rise_o = level_o & ~dly_q;
  assign fall_o = ~level_o & dly_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM high time and period in clocks, publishing duty/period with stuck detection.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int NOMINAL_PERIOD = NOMINAL_PERIOD_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic [CNT_W-1:0]  period,
  output logic              duty_valid,
  output logic              period_err,
  output logic              stuck
);
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] NOM = CNT_W'(NOMINAL_PERIOD);
  localparam logic [CNT_W-1:0] DUTY_MAX = {{(CNT_W-DUTY_W){1'b0}}, {DUTY_W{1'b1}}};
  logic level, rise, fall, timeout;
  logic [1:0] st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, high_q, high_d, period_q, period_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic valid_q, valid_d, err_q, err_d, stuck_q, stuck_d;
  pwm_capture_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .rst_n(rst_n), .pwm_i(pwm_in),
    .level_o(level), .rise_o(rise), .fall_o(fall)
  );
  // an edge in the same cycle as the timeout count suppresses the timeout
  assign timeout = (cnt_q == TO) && !rise && !fall;
  always_comb begin
    cnt_d = rise ? CNT_W'(1) : timeout ? '0 : &cnt_q ? cnt_q : cnt_q + 1'b1;
    st_d = st_q;
    high_d = high_q;
    period_d = period_q;
    duty_d = duty_q;
    err_d = err_q;
    stuck_d = stuck_q;
    valid_d = 1'b0;
    if (timeout) begin
      st_d = ST_WAIT_RISE;
      duty_d = level ? '1 : '0;
      period_d = '0;
      err_d = 1'b1;
      stuck_d = 1'b1;
      valid_d = 1'b1;
    end else if (st_q == ST_HIGH) begin
      st_d = fall ? ST_LOW : ST_HIGH;
      high_d = fall ? cnt_q : high_q;
    end else if (st_q == ST_LOW) begin
      if (rise) begin
        st_d = ST_HIGH;
        period_d = cnt_q;
        duty_d = high_q > DUTY_MAX ? '1 : high_q[DUTY_W-1:0];
        err_d = cnt_q != NOM;
        stuck_d = 1'b0;
        valid_d = 1'b1;
      end
    end else begin
      st_d = rise ? ST_HIGH : ST_WAIT_RISE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= ST_WAIT_RISE;
      cnt_q <= '0;
      high_q <= '0;
      period_q <= '0;
      duty_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      stuck_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      high_q <= high_d;
      period_q <= period_d;
      duty_q <= duty_d;
      valid_q <= valid_d;
      err_q <= err_d;
      stuck_q <= stuck_d;
    end
  end
  assign duty_cycle = duty_q;
  assign period = period_q;
  assign duty_valid = valid_q;
  assign period_err = err_q;
  assign stuck = stuck_q;
endmodule
